// File: rtl/imem_boot_loader_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Optional checksum checking is enabled with IMEM_BOOT_CHECKSUM_EN.
package imem_boot_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_DATA_W = 16;

  // NOP opcode with zero operands.
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    StClear,
    StLoad,
    StStart,
    StRun,
    StErr
  } boot_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// A same-address read during a write returns the old word.
module imem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Clears instruction memory, loads a program over valid/ready, then runs the CPU.
// Define IMEM_BOOT_CHECKSUM_EN to add ld_checksum/chk_err and the ERR state.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned       DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned       DEPTH      = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(NOP_WORD)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
`ifdef IMEM_BOOT_CHECKSUM_EN
  input  logic [DATA_W-1:0] ld_checksum,
  output logic              chk_err,
`endif
  input  logic              reload,
  output logic              cpu_reset_n,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StClear;
      ptr_q   <= '0;
      count_q <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    mem_we      = 1'b0;
    mem_wdata   = CLEAR_WORD;
    ld_ready    = 1'b0;
    cpu_reset_n = 1'b0;
    cpu_enable  = 1'b0;
    cpu_start   = 1'b0;
    busy        = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d       = sum_q;
    chk_err     = 1'b0;
`endif

    case (state_q)
      StClear: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d  = '0;
`endif
        if (ptr_q == LastAddr) begin
          ptr_d   = '0;
          state_d = StLoad;
        end
      end

      StLoad: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          // Pointer wraps naturally after the last address.
          ptr_d     = ptr_q + ADDR_W'(1);
          count_d   = count_q + (ADDR_W + 1)'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d = sum_q + ld_data;
          if (ld_last) begin
            state_d = (sum_d == ld_checksum) ? StStart : StErr;
          end else if (ptr_q == LastAddr) begin
            state_d = StErr;
          end
`else
          if (ld_last || (ptr_q == LastAddr)) begin
            state_d = StStart;
          end
`endif
        end
      end

      StStart: begin
        cpu_reset_n = 1'b1;
        cpu_enable  = 1'b1;
        cpu_start   = 1'b1;
        state_d     = StRun;
      end

      StRun: begin
        cpu_reset_n = 1'b1;
        cpu_enable  = 1'b1;
        if (reload) begin
          state_d = StClear;
          ptr_d   = '0;
          count_d = '0;
        end
      end

`ifdef IMEM_BOOT_CHECKSUM_EN
      StErr: begin
        chk_err = 1'b1;
      end
`endif

      default: begin
        state_d = StClear;
        ptr_d   = '0;
        count_d = '0;
      end
    endcase
  end

  assign load_count = count_q;

  // Reset leaves memory contents untouched.
  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (mem_we && !reset),
    .waddr(ptr_q),
    .wdata(mem_wdata),
    .raddr(i_addr),
    .rdata(i_datain)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader; checksum cases run when
// IMEM_BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_datain;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic [15:0] ld_checksum = '0;
  logic        reload = 1'b0;
  logic        cpu_reset_n, cpu_enable, cpu_start, busy;
  logic [8:0]  load_count;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic        chk_err;
`endif

  imem_boot_loader dut (
    .clock      (clock),
    .reset      (reset),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
`ifdef IMEM_BOOT_CHECKSUM_EN
    .ld_checksum(ld_checksum),
    .chk_err    (chk_err),
`endif
    .reload     (reload),
    .cpu_reset_n(cpu_reset_n),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .load_count (load_count)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          start_q[$];
  logic [15:0] rd_q[$];
  logic        rd_req = 1'b0;
  logic [15:0] model[256];
  bit          in_err = 1'b0;
  logic [15:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses start or a read is presented.
  always @(negedge clock) begin
    if (cpu_start === 1'b1) begin
      if (start_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_start: got cpu_start=1 expected 0 at %0t", $time);
      end else begin
        check("start_count", 32'(load_count), 32'(start_q.pop_front()));
        check("start_rstn", 32'(cpu_reset_n), 32'd1);
        check("start_en", 32'(cpu_enable), 32'd1);
        check("start_rdy", 32'(ld_ready), 32'd0);
      end
    end
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_queue: got read with empty queue expected entry at %0t", $time);
      end else begin
        check($sformatf("rd_%02h", i_addr), 32'(i_datain), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // After any clear the memory model is all NOPs.
  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_err = 1'b0;
    model_clear();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    check("reload_rstn", 32'(cpu_reset_n), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_cnt", 32'(load_count), 32'd0);
    model_clear();
  endtask

  task automatic wait_ready();
    int c = 0;
    while (ld_ready !== 1'b1 && c < 1000) begin
      if (c > 0 && c < 256 && (ld_ready !== 1'b0 || busy !== 1'b1)) begin
        $display("FAIL clear_outputs: got rdy=%b busy=%b expected 0/1 at %0t",
                 ld_ready, busy, $time);
        n_err++;
      end
      step();
      c++;
    end
    check("ready_latency", 32'(c), 32'd256);
  endtask

  task automatic restart();
    if (in_err) do_reset();
    else do_reload();
    wait_ready();
  endtask

  task automatic load(input logic [15:0] p[$], input bit use_last, input bit gaps,
                      input bit bad_sum);
    logic [15:0] sum = '0;
    bit ok = 1'b1;
    foreach (p[i]) sum += p[i];
`ifdef IMEM_BOOT_CHECKSUM_EN
    ok = use_last && !bad_sum;
`endif
    if (ok) start_q.push_back(p.size());
    for (int i = 0; i < 256; i++) model[i] = (i < p.size()) ? p[i] : 16'h0000;
    foreach (p[i]) begin
      while (gaps && $urandom_range(1, 0) == 1) begin
        ld_valid = 1'b0;
        step();
        if (ld_ready !== 1'b1) begin
          $display("FAIL gap_ready: got %b expected 1 at %0t", ld_ready, $time);
          n_err++;
        end
      end
      ld_valid    = 1'b1;
      ld_data     = p[i];
      ld_last     = use_last && (i == p.size() - 1);
      ld_checksum = sum + 16'(bad_sum);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    step();
    if (ok) begin
      check("run_start", 32'(cpu_start), 32'd0);
      check("run_rstn", 32'(cpu_reset_n), 32'd1);
      check("run_en", 32'(cpu_enable), 32'd1);
      check("run_rdy", 32'(ld_ready), 32'd0);
      check("run_busy", 32'(busy), 32'd0);
      check("run_cnt", 32'(load_count), 32'(p.size()));
    end else begin
`ifdef IMEM_BOOT_CHECKSUM_EN
      check("err_flag", 32'(chk_err), 32'd1);
`endif
      check("err_rstn", 32'(cpu_reset_n), 32'd0);
      check("err_en", 32'(cpu_enable), 32'd0);
      check("err_busy", 32'(busy), 32'd0);
      in_err = 1'b1;
    end
  endtask

  task automatic rd_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      i_addr = 8'(a);
      rd_req = 1'b1;
      rd_q.push_back(model[a]);
      step();
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    do_reset();
    check("rst_rdy", 32'(ld_ready), 32'd0);
    check("rst_rstn", 32'(cpu_reset_n), 32'd0);
    check("rst_en", 32'(cpu_enable), 32'd0);
    check("rst_start", 32'(cpu_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cnt", 32'(load_count), 32'd0);
    wait_ready();

    // Fill with 16'hFFFF, then a bare reset must clear everything back to NOP.
    prog = {};
    for (int i = 0; i < 256; i++) prog.push_back(16'hFFFF);
    load(prog, 1'b0, 1'b0, 1'b0);
    rd_range(254, 255);
    do_reset();
    wait_ready();
    rd_range(0, 255);

    prog = {16'h1001, 16'h2002, 16'h3003};
    load(prog, 1'b1, 1'b0, 1'b0);
    rd_range(0, 3);

    // Full-depth load with no last marker.
    restart();
    prog = {};
    for (int i = 0; i < 256; i++) prog.push_back(16'(i));
    load(prog, 1'b0, 1'b0, 1'b0);
    rd_range(250, 255);
    rd_range(0, 3);

    // Same random program with and without valid gaps.
    prog = {};
    for (int i = 0; i < 10; i++) prog.push_back(16'($urandom));
    restart();
    load(prog, 1'b1, 1'b0, 1'b0);
    rd_range(0, 10);
    restart();
    load(prog, 1'b1, 1'b1, 1'b0);
    rd_range(0, 10);

    // reload while in LOAD is ignored.
    restart();
    reload = 1'b1;
    step();
    reload = 1'b0;
    check("reload_in_load_rdy", 32'(ld_ready), 32'd1);
    check("reload_in_load_busy", 32'(busy), 32'd1);
    prog = {16'hA5A5, 16'h5A5A};
    load(prog, 1'b1, 1'b0, 1'b0);
    rd_range(0, 2);

    // Reset mid-load discards the partial program.
    restart();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 16'hBEE0 + 16'(i);
      step();
    end
    ld_valid = 1'b0;
    check("partial_cnt", 32'(load_count), 32'd5);
    do_reset();
    check("abort_cnt", 32'(load_count), 32'd0);
    check("abort_rdy", 32'(ld_ready), 32'd0);
    wait_ready();
    rd_range(0, 5);

    // reset and reload together: reset wins, clear restarts from scratch.
    prog = {16'h0F0F, 16'hF0F0};
    load(prog, 1'b1, 1'b0, 1'b0);
    reset  = 1'b1;
    reload = 1'b1;
    step();
    reset  = 1'b0;
    reload = 1'b0;
    in_err = 1'b0;
    model_clear();
    check("both_cnt", 32'(load_count), 32'd0);
    check("both_busy", 32'(busy), 32'd1);
    wait_ready();
    rd_range(0, 2);

`ifdef IMEM_BOOT_CHECKSUM_EN
    prog = {16'h0001, 16'h0002};
    load(prog, 1'b1, 1'b0, 1'b0);
    restart();
    load(prog, 1'b1, 1'b0, 1'b1);
    reload = 1'b1;
    step();
    reload = 1'b0;
    repeat (20) step();
    check("err_sticky", 32'(chk_err), 32'd1);
    check("err_sticky_rstn", 32'(cpu_reset_n), 32'd0);
    do_reset();
    check("err_cleared", 32'(chk_err), 32'd0);
    wait_ready();
`endif

    step();
    check("start_q_empty", 32'(start_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Instruction-memory front end sitting directly upstream of the pipelined CPU core; drives its instruction fetch port (i_addr in, instruction word out) and its run controls.
- After reset, clears all 256 instruction words to NOP (16'h0000), then accepts a program over a valid/ready stream.
- Releases the CPU from reset and issues a one-cycle start pulse; serves fetches combinationally while the CPU runs.

Parameters:
ADDR_W, 8, instruction address width
DATA_W, 16, instruction word width
DEPTH, 256, word count (must equal 2**ADDR_W)
CLEAR_WORD, 16'h0000, fill value (NOP opcode, zero operands)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
i_addr  in  ADDR_W  CPU fetch address
i_datain  out  DATA_W  instruction word = mem[i_addr], combinational
ld_valid  in  1  load word valid
ld_ready  out  1  loader accepts word
ld_data  in  DATA_W  program word
ld_last  in  1  final word of program
reload  in  1  single-cycle request to re-program, honoured only in RUN
cpu_reset_n  out  1  active-low reset to CPU core
cpu_enable  out  1  CPU enable
cpu_start  out  1  one-cycle CPU start pulse
busy  out  1  high in CLEAR or LOAD
load_count  out  ADDR_W+1  words accepted in current load, 0..256

Behaviour:
- Reset is synchronous and active-high, single clock. Reset cycle: state<=CLEAR, ptr<=0, load_count<=0. Memory contents are untouched by reset itself.
- Outputs are Moore-decoded from state. After reset: ld_ready=0, cpu_reset_n=0, cpu_enable=0, cpu_start=0, busy=1.
- Five states:
  - CLEAR:
    - Writes CLEAR_WORD at ptr each cycle, ptr++.
    - After the write to address DEPTH-1: ptr<=0, go to LOAD.
    - Takes exactly DEPTH cycles.
  - LOAD:
    - ld_ready=1. A transfer occurs when ld_valid && ld_ready.
    - On transfer: mem[ptr]<=ld_data, ptr++, load_count++.
    - Go to START on a transfer with ld_last=1, or on a transfer at ptr==DEPTH-1. ptr wraps to 0, so there is no overflow.
    - ld_valid=0 cycles hold state; gaps are unlimited.
  - START: cpu_reset_n=1, cpu_enable=1, cpu_start=1 for exactly one cycle, then RUN.
  - RUN:
    - cpu_reset_n=1, cpu_enable=1, cpu_start=0.
    - reload=1 -> CLEAR with ptr<=0, load_count<=0; CPU reset reasserts in the next cycle.
  - ERR (optional feature only): cpu_reset_n=0, cpu_enable=0, busy=0. Exited only by reset.
- reload outside RUN is ignored.
- Reset mid-CLEAR or mid-LOAD restarts CLEAR from address 0; a partial program is discarded.
- reset and reload in the same cycle: reset wins.
- Read port i_datain is always valid combinationally, including during CLEAR/LOAD. The CPU is held in reset then, so the value is don't-care.
- A read and write to the same address in the same cycle returns the old word.
- load_count holds its final value through START/RUN until CLEAR.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - Extra input ld_checksum (DATA_W) is sampled with the ld_last transfer.
  - A running 16-bit modulo sum of accepted words, including the last one, is compared against it.
  - Match -> START. Mismatch -> ERR.
  - Extra output chk_err=1 in ERR.
  - The auto-transition at ptr==DEPTH-1 without ld_last -> ERR.
  - Sum clears in CLEAR.
- Undefined: no ld_checksum/chk_err ports, no ERR state; behaviour as above.

Decomposition:
- Shared package: state encoding (CLEAR, LOAD, START, RUN, ERR), NOP_WORD constant, ADDR_W/DATA_W defaults.
- Sub-module imem_ram: DEPTH x DATA_W array, one synchronous write port (we, waddr, wdata), one asynchronous read port. The FSM and counters stay in imem_boot_loader.

Test Plan:
- Preload RAM with 16'hFFFF, assert reset 1 cycle -> ld_ready rises exactly 256 cycles after reset deasserts; every address reads 16'h0000 via i_addr sweep.
- Load 3 words 16'h1001, 16'h2002, 16'h3003 (last on third) -> cpu_start high exactly one cycle after third transfer; cpu_reset_n=1, cpu_enable=1; load_count=3; i_addr=0..3 returns 1001, 2002, 3003, 0000.
- Load 256 words 16'h0000..16'h00FF, ld_last never asserted -> START after 256th transfer, load_count=256, i_addr=8'hFF returns 16'h00FF.
- Random ld_valid gaps (50% duty) during 10-word load -> data and count identical to gap-free run; ld_ready low outside LOAD.
- RUN, pulse reload -> cpu_reset_n=0 next cycle, busy=1, 256 clear cycles, new 2-word program readable. Reset asserted mid-LOAD after 5 words -> load_count=0, CLEAR restarts at address 0.
- With IMEM_BOOT_CHECKSUM_EN: words 16'h0001, 16'h0002, ld_checksum=16'h0003 -> START; ld_checksum=16'h0004 -> ERR, chk_err=1, cpu_start never pulses until reset.
